condiciona_entradas: RTL and testbench
======================================

CONDICIONA_ENTRADAS -- requirements
Module: condiciona_entradas

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50000, meaning consecutive clock cycles a synchronized input must differ from its stable value before the change is accepted (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Botao  input  1  raw feed pushbutton, active-low (0 = pressed), asynchronous to clk.
REQ-005 SHALL have port LD  input  1  raw on/off switch, 1 = on, asynchronous.
REQ-006 SHALL have ports T2s, T4s, T8s  input  1 each  raw interval-select switches, 1 = selected, asynchronous.
REQ-007 SHALL have port ld_o  output  1  debounced LD.
REQ-008 SHALL have port press_pulse  output  1  one-cycle pulse per accepted button press.
REQ-009 SHALL have port sel  output  2  interval code: 00 none/invalid, 01 2 s, 10 4 s, 11 8 s.
REQ-010 SHALL have port erro  output  1  more than one interval switch active.
REQ-011 SHALL have port sel_change  output  1  one-cycle pulse when sel changes.

Function
REQ-012 SHALL pass each of the 5 raw inputs through its own 2-flop synchronizer before any other use.
REQ-013 SHALL keep, per input, a stable register and a debounce counter of ceil(log2(DEB_CYCLES)) bits.
REQ-014 SHALL clear the counter on any cycle where synchronized value equals stable value.
REQ-015 SHALL increment the counter on each cycle where synchronized value differs from stable value; on the DEB_CYCLES-th consecutive differing cycle it SHALL load stable with the synchronized value and clear the counter.
REQ-016 SHALL therefore give a raw change held steady a stable-register latency of exactly DEB_CYCLES+2 rising edges, counted from the first edge that samples the new raw value.
REQ-017 SHALL reject any raw pulse or bounce shorter than DEB_CYCLES cycles (after synchronization) with no stable change and no counter wrap.
REQ-018 SHALL drive ld_o directly from the LD stable register.
REQ-019 SHALL assert press_pulse for exactly one cycle, in the cycle after the Botao stable register goes 1->0, only if ld_o was 1 in the cycle of that transition; holding the button SHALL NOT produce further pulses; release (0->1) SHALL NOT produce a pulse.
REQ-020 SHALL decode the three interval stable registers: exactly one set -> sel = its code, erro = 0; none set -> sel = 00, erro = 0; two or three set -> sel = 00, erro = 1.
REQ-021 SHALL register sel and erro one cycle after the stable registers change, giving raw-to-sel latency DEB_CYCLES+3 edges.
REQ-022 SHALL assert sel_change for exactly one cycle, coincident with the first cycle the new registered sel value appears; an erro-only change with sel unchanged SHALL NOT pulse.
REQ-023 SHALL decode sel and erro independently of ld_o.
REQ-024 SHALL handle simultaneous stable changes on several inputs in the same cycle with no priority effects; each output follows its own rule.

Reset
REQ-025 SHALL, on reset = 1, asynchronously and immediately clear all synchronizer flops, counters, ld_o, press_pulse, sel, erro and sel_change to 0; the Botao synchronizer and stable register SHALL reset to 1 (released).
REQ-026 SHALL discard any debounce in progress when reset is asserted mid-count; after release, an input still held SHALL need a full DEB_CYCLES+2 edges to be accepted.
REQ-027 SHALL, after reset release with Botao held low and LD = 1, accept LD and Botao in the same cycle and SHALL NOT emit press_pulse for that press, because ld_o was 0 in the transition cycle.

Verification (DEB_CYCLES = 4)
REQ-028 SHALL cover reset with all raw inputs toggling -> all outputs 0 while reset is high and 1 cycle after release.
REQ-029 SHALL cover LD 0->1 held -> ld_o rises on edge 6; LD high for 3 cycles only -> ld_o stays 0.
REQ-030 SHALL cover, with ld_o = 1, Botao low 3 cycles / high 1 / low 100 -> exactly one press_pulse, on edge 7 after the final fall; no pulse on release.
REQ-031 SHALL cover T4s = 1 -> sel = 10 with sel_change high for 1 cycle at edge 7; then T8s = 1 -> sel = 00, erro = 1, one sel_change pulse; then T4s = 0 -> sel = 11, erro = 0.
REQ-032 SHALL cover ld_o = 0 with a clean button press -> press_pulse never asserts.
REQ-033 SHALL cover reset pulse at count 3 of an LD rise -> ld_o stays 0; ld_o rises 6 edges after reset release.

Source files
------------

// File: rtl/condiciona_entradas.sv
// rtl/condiciona_entradas.sv - synchronize, debounce and decode the feeder panel inputs

// One input channel: 2-flop synchronizer followed by a stability counter.
module condiciona_entradas_deb #(
  parameter int   DEB_CYCLES = 50000,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int            CW   = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous raw input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= RST_VAL;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// Conditions the panel switches and feed button into clean control signals.
module condiciona_entradas #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Botao,
  input  logic       LD,
  input  logic       T2s,
  input  logic       T4s,
  input  logic       T8s,
  output logic       ld_o,
  output logic       press_pulse,
  output logic [1:0] sel,
  output logic       erro,
  output logic       sel_change
);

  logic       btn_st;
  logic       ld_st;
  logic       t2_st;
  logic       t4_st;
  logic       t8_st;
  logic       btn_prev;
  logic       ld_prev;
  logic [1:0] sel_d;
  logic       erro_d;

  // The button idles high (released), so its channel resets to 1.
  condiciona_entradas_deb #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_btn (
    .clk(clk), .reset(reset), .raw(Botao), .stable(btn_st));
  condiciona_entradas_deb #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_ld (
    .clk(clk), .reset(reset), .raw(LD), .stable(ld_st));
  condiciona_entradas_deb #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_t2 (
    .clk(clk), .reset(reset), .raw(T2s), .stable(t2_st));
  condiciona_entradas_deb #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_t4 (
    .clk(clk), .reset(reset), .raw(T4s), .stable(t4_st));
  condiciona_entradas_deb #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_t8 (
    .clk(clk), .reset(reset), .raw(T8s), .stable(t8_st));

  assign ld_o = ld_st;

  // Press edge: the stable button fell last cycle while the feeder was on
  // before that fall (ld_prev holds ld_o from the transition cycle).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev    <= 1'b1;
      ld_prev     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      btn_prev    <= btn_st;
      ld_prev     <= ld_st;
      press_pulse <= btn_prev & ~btn_st & ld_prev;
    end
  end

  // Interval decode: a single active switch selects, several flag an error.
  always_comb begin
    sel_d  = 2'b00;
    erro_d = 1'b0;
    case ({t2_st, t4_st, t8_st})
      3'b000:  begin sel_d = 2'b00; erro_d = 1'b0; end
      3'b100:  begin sel_d = 2'b01; erro_d = 1'b0; end
      3'b010:  begin sel_d = 2'b10; erro_d = 1'b0; end
      3'b001:  begin sel_d = 2'b11; erro_d = 1'b0; end
      default: begin sel_d = 2'b00; erro_d = 1'b1; end
    endcase
  end

  // Register the decode; sel_change marks the first cycle of a new sel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel        <= 2'b00;
      erro       <= 1'b0;
      sel_change <= 1'b0;
    end else begin
      sel        <= sel_d;
      erro       <= erro_d;
      sel_change <= (sel_d != sel);
    end
  end

endmodule

// File: tb/tb_condiciona_entradas.sv
// tb/tb_condiciona_entradas.sv - scoreboard bench for condiciona_entradas

module tb_condiciona_entradas;

  logic       clk = 1'b0;
  logic       reset;
  logic       Botao;
  logic       LD;
  logic       T2s;
  logic       T4s;
  logic       T8s;
  logic       ld_o;
  logic       press_pulse;
  logic [1:0] sel;
  logic       erro;
  logic       sel_change;

  typedef struct {
    int         kind;   // 0 ld_o change, 1 press_pulse, 2 sel_change
    int         cyc;
    logic [1:0] sel;
    logic       erro;
    logic       ld;
  } ev_t;

  ev_t  sbq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  logic ld_last    = 1'b0;

  condiciona_entradas #(.DEB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .Botao(Botao), .LD(LD), .T2s(T2s), .T4s(T4s),
    .T8s(T8s), .ld_o(ld_o), .press_pulse(press_pulse), .sel(sel), .erro(erro),
    .sel_change(sel_change));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int c, input logic [1:0] s,
                      input logic e, input logic l);
    ev_t ev;
    ev.kind = kind; ev.cyc = c; ev.sel = s; ev.erro = e; ev.ld = l;
    sbq.push_back(ev);
  endtask

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic match(input int kind);
    ev_t e;
    compared++;
    if (sbq.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d ld=%b sel=%b erro=%b",
               kind, cyc, ld_o, sel, erro);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          (kind == 0 && ld_o !== e.ld) ||
          (kind == 2 && (sel !== e.sel || erro !== e.erro))) begin
        mismatched++;
        $display("FAIL event got kind=%0d cyc=%0d ld=%b sel=%b erro=%b expected kind=%0d cyc=%0d ld=%b sel=%b erro=%b",
                 kind, cyc, ld_o, sel, erro, e.kind, e.cyc, e.ld, e.sel, e.erro);
      end
    end
  endtask

  // Monitor: every observable output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      ld_last = 1'b0;
    end else begin
      if (ld_o !== ld_last) begin
        match(0);
        ld_last = ld_o;
      end
      if (press_pulse) match(1);
      if (sel_change)  match(2);
    end
  end

  initial begin
    reset = 1'b1; Botao = 1'b1; LD = 1'b0; T2s = 1'b0; T4s = 1'b0; T8s = 1'b0;

    // reset held while raw inputs toggle
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("reset_hold", {ld_o, press_pulse, sel, erro, sel_change}, 6'b0);
      {Botao, LD, T2s, T4s, T8s} = 5'($urandom);
    end
    tick(1);
    Botao = 1'b1; LD = 1'b0; T2s = 1'b0; T4s = 1'b0; T8s = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("post_release", {ld_o, press_pulse, sel, erro, sel_change}, 6'b0);
    tick(10);

    // LD high for only 3 cycles: rejected
    LD = 1'b1; tick(3); LD = 1'b0; tick(12);

    // LD held: ld_o rises on edge 6
    LD = 1'b1; push(0, cyc + 6, 2'b00, 1'b0, 1'b1); tick(12);

    // bounce: low 3 / high 1 / low 100 -> single pulse 7 edges after final fall
    Botao = 1'b0; tick(3); Botao = 1'b1; tick(1);
    Botao = 1'b0; push(1, cyc + 7, 2'b00, 1'b0, 1'b0); tick(100);
    Botao = 1'b1; tick(12);

    // interval selection
    T4s = 1'b1; push(2, cyc + 7, 2'b10, 1'b0, 1'b0); tick(12);
    T8s = 1'b1; push(2, cyc + 7, 2'b00, 1'b1, 1'b0); tick(12);
    T4s = 1'b0; push(2, cyc + 7, 2'b11, 1'b0, 1'b0); tick(12);
    T8s = 1'b0; push(2, cyc + 7, 2'b00, 1'b0, 1'b0); tick(12);
    T2s = 1'b1; T4s = 1'b1; tick(12);                      // erro-only change
    T4s = 1'b0; push(2, cyc + 7, 2'b01, 1'b0, 1'b0); tick(12);
    T2s = 1'b0; push(2, cyc + 7, 2'b00, 1'b0, 1'b0); tick(12);

    // feeder off: a clean press yields no pulse
    LD = 1'b0; push(0, cyc + 6, 2'b00, 1'b0, 1'b0); tick(12);
    Botao = 1'b0; tick(20); Botao = 1'b1; tick(15);

    // reset at count 3 of an LD rise discards the debounce
    LD = 1'b1; tick(5);
    reset = 1'b1; tick(2);
    reset = 1'b0; push(0, cyc + 6, 2'b00, 1'b0, 1'b1); tick(12);

    // reset release with button held and LD on: no press pulse
    reset = 1'b1; Botao = 1'b0; tick(3);
    reset = 1'b0; push(0, cyc + 6, 2'b00, 1'b0, 1'b1); tick(15);
    Botao = 1'b1; tick(15);

    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL pending_events got=%0d expected=0 next_kind=%0d next_cyc=%0d",
               sbq.size(), sbq[0].kind, sbq[0].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
